uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver and the receive-side partner of the UART clock generator. It consumes the `rxd_ena` oversampling strobe, which runs at 16× the bit rate, and deserialises the asynchronous `rxd` line. Each frame is start bit, DATA_BITS data bits LSB-first, an optional parity bit, then one stop bit. Received bytes are presented on a valid/ready interface together with framing and parity status, and overruns are flagged.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5–8.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even; ignored when `PARITY_EN`=0.
- `clki` in 1: sole clock; every flop is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rxd_ena` in 1: one-`clki`-wide sample strobe at 16× the bit rate.
- `rxd` in 1: asynchronous serial line, idles high.
- `rx_data` out DATA_BITS: received data, LSB = first bit on the wire.
- `rx_valid` out 1: `rx_data`, `frame_err` and `parity_err` are valid.
- `rx_ready` in 1: consumer accepts; transfer occurs when `rx_valid & rx_ready`.
- `frame_err` out 1: stop bit sampled 0; qualified by `rx_valid`.
- `parity_err` out 1: parity mismatch; qualified by `rx_valid`; always 0 when `PARITY_EN`=0.
- `overrun` out 1: one-`clki` pulse when a completed frame is dropped.

## Operation
- **Synchroniser:** `rxd` passes through 2 flops on every `clki`. Both flops reset to 1. All logic uses the synchronised value `rxs`.
- **Sampling:** everything below advances only on cycles where `rxd_ena`=1.
  - `smp_cnt` is 4 bits and wraps 15→0.
  - `last_rxs` holds `rxs` from the previous strobe; it resets to 1.
- **Bit decision:** each bit value is the 2-of-3 majority of `rxs` at `smp_cnt` = 7, 8 and 9. The decision is taken on the strobe where `smp_cnt`=9.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** if `rxs`=0 and `last_rxs`=1 (falling edge), go to START with `smp_cnt`←1, counting the detecting strobe as sample 0. A line held low, such as a break, therefore does not retrigger.
  - **START:** at decision, a majority of 1 is a false start and returns to IDLE. Otherwise, continue to `smp_cnt`=15, then go to DATA with `bit_cnt`←0.
  - **DATA:** at decision, shift the bit into `shreg[bit_cnt]`. At `smp_cnt`=15:
    - if `bit_cnt`=DATA_BITS-1, go to PARITY when `PARITY_EN`=1, else to STOP;
    - otherwise increment `bit_cnt`.
  - **PARITY:** at decision, latch `par_bad` = (XOR of data bits ^ sampled parity bit) ^ `PARITY_ODD`. Go to STOP at `smp_cnt`=15.
  - **STOP:** at decision, commit the frame (see below) and return to IDLE immediately. This leaves half a bit of margin for the next start edge.
- **Commit:**
  - If `rx_valid`=1 and `rx_ready`=0 in the commit cycle: the new frame is discarded, the held frame is unchanged, and `overrun` pulses.
  - Otherwise: load `rx_data`←`shreg`, `frame_err`←(stop bit == 0), `parity_err`←`par_bad`, and set `rx_valid`←1.
- **Handshake:** `rx_valid` clears on the edge after `rx_valid & rx_ready` unless a commit occurs in the same cycle. A commit in the same cycle as an accept loads the new frame, keeps `rx_valid`=1, and does not raise `overrun`.
- **Mid-frame reset:** `rst_n`=0 discards any partial frame and returns to IDLE.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, state IDLE, both counters 0.
- **Output latency:** `rx_valid` rises on the `clki` edge that registers the stop-bit decision strobe (`smp_cnt`=9 in STOP). It is registered with no combinational path from `rxd`.
- **Input latency:** 2 `clki` of synchroniser delay before `rxd` is seen.
- **Strobe gaps:** `rxd_ena` gaps of any length are legal. State is frozen between strobes.
- **Handshake independence:** `rx_ready` may be asserted on any cycle, independent of `rxd_ena`.

## Structure
- **Package `uart_pkg`:**
  - `uart_rx_state_e` enum;
  - `OSR`=16;
  - `SMP_MID_LO`=7, `SMP_MID`=8, `SMP_MID_HI`=9;
  - `SMP_LAST`=15.
- **Sub-module `uart_rx_sync`:** the 2-flop synchroniser with a reset value parameter (set to 1 here). It is reusable by other asynchronous inputs.

## Test plan
- **Single frame:** frame 0xA5, 8N1, strobe every 4 `clki`, `rx_ready`=1 → `rx_data`=0xA5, `rx_valid` high for 1 cycle, both error flags 0.
- **False start:** `rxd` low for 4 strobes, then high → no `rx_valid`; the FSM is back in IDLE and a following 0x3C is received correctly.
- **Framing error and break:** stop bit driven 0 → `rx_data`=0x00 and `frame_err`=1. With `rxd` then held low for 40 strobes there is no second frame; after `rxd` returns high, 0x55 is received correctly.
- **Parity:** `PARITY_EN`=1, `PARITY_ODD`=0, frame 0x0F.
  - Parity bit 0 → `parity_err`=0.
  - Parity bit 1 → `parity_err`=1.
- **Overrun and simultaneous accept:** `rx_ready`=0 while 0x11 then 0x22 arrive → `overrun` pulses once and `rx_data` stays 0x11. Then receive 0x33 with `rx_ready` asserted exactly in the commit cycle → `rx_data`=0x33, `rx_valid` stays 1, no `overrun`.
- **Reset mid-frame:** `rst_n`=0 for 1 cycle during data bit 3 → all outputs return to their reset values, and the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_e;

    // Oversampling ratio of the rxd_ena strobe relative to the bit rate.
    localparam int OSR   = 16;
    localparam int SMP_W = $clog2(OSR);

    // Sample points within one bit: the three centre samples vote, the
    // decision lands on the last of them, and the bit ends on SMP_LAST.
    localparam logic [SMP_W-1:0] SMP_MID_LO = SMP_W'(7);
    localparam logic [SMP_W-1:0] SMP_MID    = SMP_W'(8);
    localparam logic [SMP_W-1:0] SMP_MID_HI = SMP_W'(9);
    localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'(15);

    // 2-of-3 vote used for every bit decision.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input. The reset
// value is a parameter so an idle-high line does not look like an edge when
// reset is released.
module uart_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clki,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    // Shift the asynchronous input through the flop chain every clock.
    always_ff @(posedge clki) begin
        if (!rst_n) begin
            sync_reg <= {STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, majority-voted bit decisions, optional
// parity, one stop bit, and a valid/ready output holding one frame with
// overrun reporting when a completed frame cannot be stored.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clki,
    input  logic                 rst_n,
    input  logic                 rxd_ena,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    // Bit counter covers up to 8 data bits (index 0..7).
    localparam int                   BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic                 PAR_EN    = (PARITY_EN != 0);
    localparam logic                 PAR_ODD   = (PARITY_ODD != 0);

    logic rxs;

    uart_rx_sync #(
        .STAGES  (2),
        .RST_VAL (1'b1)
    ) u_sync (
        .clki  (clki),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxs)
    );

    uart_rx_state_e        state_reg;
    logic [SMP_W-1:0]      smp_cnt_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg;
    logic                  last_rxs_reg;
    logic                  smp_lo_reg;
    logic                  smp_mid_reg;
    logic [DATA_BITS-1:0]  shreg_reg;
    logic                  par_bad_reg;

    logic [DATA_BITS-1:0]  rx_data_reg;
    logic                  rx_valid_reg;
    logic                  frame_err_reg;
    logic                  parity_err_reg;
    logic                  overrun_reg;

    logic bit_maj;
    logic at_decision;
    logic at_last;
    logic commit;

    // The vote combines the two stored centre samples with the live third one,
    // so the decision is available on the SMP_MID_HI strobe itself.
    assign bit_maj     = majority3(smp_lo_reg, smp_mid_reg, rxs);
    assign at_decision = (smp_cnt_reg == SMP_MID_HI);
    assign at_last     = (smp_cnt_reg == SMP_LAST);
    assign commit      = rxd_ena && (state_reg == ST_STOP) && at_decision;

    // Frame FSM: tracks bit position and deserialises, advancing only on strobes.
    always_ff @(posedge clki) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            smp_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            last_rxs_reg <= 1'b1;
            smp_lo_reg   <= 1'b1;
            smp_mid_reg  <= 1'b1;
            shreg_reg    <= '0;
            par_bad_reg  <= 1'b0;
        end else if (rxd_ena) begin
            last_rxs_reg <= rxs;
            smp_cnt_reg  <= smp_cnt_reg + 1'b1;
            if (smp_cnt_reg == SMP_MID_LO) begin
                smp_lo_reg <= rxs;
            end
            if (smp_cnt_reg == SMP_MID) begin
                smp_mid_reg <= rxs;
            end

            case (state_reg)
                ST_IDLE: begin
                    // Only a high-to-low transition starts a frame, so a line
                    // held low (break) cannot retrigger reception.
                    if (!rxs && last_rxs_reg) begin
                        state_reg   <= ST_START;
                        smp_cnt_reg <= SMP_W'(1);
                        par_bad_reg <= 1'b0;
                    end else begin
                        smp_cnt_reg <= '0;
                    end
                end

                ST_START: begin
                    if (at_decision && bit_maj) begin
                        // Glitch shorter than half a bit: not a real start.
                        state_reg   <= ST_IDLE;
                        smp_cnt_reg <= '0;
                    end else if (at_last) begin
                        state_reg   <= ST_DATA;
                        bit_cnt_reg <= '0;
                    end
                end

                ST_DATA: begin
                    if (at_decision) begin
                        shreg_reg[bit_cnt_reg] <= bit_maj;
                    end
                    if (at_last) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (at_decision) begin
                        par_bad_reg <= (^shreg_reg) ^ bit_maj ^ PAR_ODD;
                    end
                    if (at_last) begin
                        state_reg <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    // Leave mid-stop-bit so the next start edge has half a
                    // bit of slack against clock mismatch.
                    if (at_decision) begin
                        state_reg   <= ST_IDLE;
                        smp_cnt_reg <= '0;
                    end
                end

                default: begin
                    state_reg   <= ST_IDLE;
                    smp_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Output holding register: commit a frame, drop it on overrun, or clear on accept.
    always_ff @(posedge clki) begin
        if (!rst_n) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (commit) begin
                if (rx_valid_reg && !rx_ready) begin
                    // Held frame not yet taken: keep it, lose the new one.
                    overrun_reg <= 1'b1;
                end else begin
                    // Covers the same-cycle accept case too: valid stays set.
                    rx_data_reg    <= shreg_reg;
                    frame_err_reg  <= ~bit_maj;
                    parity_err_reg <= par_bad_reg;
                    rx_valid_reg   <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance, each on its own
// serial line, driven bit by bit at 16 strobes per bit. Expected frames come
// from a small model of the frame format (data, stop, parity arithmetic).
module tb_uart_rx;

    localparam bit P_ODD = 1'b0;

    logic clki = 1'b0;
    always #5 clki = ~clki;

    logic       rst_n;
    logic       rxd_ena;
    logic       rxd;
    logic       rxd_p;
    logic       rx_ready;
    logic       rx_ready_p;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [7:0] rx_data_p;
    logic       rx_valid_p;
    logic       frame_err_p;
    logic       parity_err_p;
    logic       overrun_p;

    int checks = 0;
    int errors = 0;

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clki       (clki),
        .rst_n      (rst_n),
        .rxd_ena    (rxd_ena),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clki       (clki),
        .rst_n      (rst_n),
        .rxd_ena    (rxd_ena),
        .rxd        (rxd_p),
        .rx_data    (rx_data_p),
        .rx_valid   (rx_valid_p),
        .rx_ready   (rx_ready_p),
        .frame_err  (frame_err_p),
        .parity_err (parity_err_p),
        .overrun    (overrun_p)
    );

    // Strobe generator: every 4 clocks, or a random 4..7 when rand_gaps is set.
    bit rand_gaps = 1'b0;
    int gap_left  = 0;
    initial rxd_ena = 1'b0;
    always @(posedge clki) begin
        #1;
        if (gap_left == 0) begin
            rxd_ena  = 1'b1;
            gap_left = rand_gaps ? int'($urandom_range(6, 3)) : 3;
        end else begin
            rxd_ena  = 1'b0;
            gap_left = gap_left - 1;
        end
    end

    // Monitor: record transfers, valid-high cycles and overrun pulses.
    logic [9:0] got_q[$];
    logic [9:0] gotp_q[$];
    int valid_cycles = 0;
    int ovr_cnt      = 0;
    int ovr_cnt_p    = 0;
    always @(negedge clki) begin
        if (rx_valid && rx_ready)     got_q.push_back({frame_err, parity_err, rx_data});
        if (rx_valid_p && rx_ready_p) gotp_q.push_back({frame_err_p, parity_err_p, rx_data_p});
        if (rx_valid)  valid_cycles++;
        if (overrun)   ovr_cnt++;
        if (overrun_p) ovr_cnt_p++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {frame_err, parity_err, data}: stop bit 0 is a framing error;
    // the data+parity one-count must be even (or odd for odd parity).
    function automatic logic [9:0] model(input logic [7:0] d, input bit par_en,
                                         input bit par_bit, input bit stop_bit);
        int ones;
        bit pe;
        ones = $countones(d) + (par_en ? int'(par_bit) : 0);
        pe   = par_en && ((ones % 2) != int'(P_ODD));
        return {~stop_bit, pe, d};
    endfunction

    task automatic wait_strobe();
        do @(posedge clki); while (!rxd_ena);
    endtask

    task automatic drive(input bit to_p, input logic v);
        #1;
        if (to_p) rxd_p = v;
        else      rxd   = v;
    endtask

    // Hold one bit for 16 strobes; optionally raise rx_ready only in the
    // cycle of the 10th strobe (the stop-bit decision / commit cycle).
    task automatic bit_period(input bit to_p, input logic v, input bit ready_at_commit);
        drive(to_p, v);
        for (int k = 0; k < 16; k++) begin
            if (ready_at_commit && k == 9) begin
                #2;
                while (!rxd_ena) begin
                    @(posedge clki);
                    #2;
                end
                rx_ready = 1'b1;
                @(posedge clki);
                #1 rx_ready = 1'b0;
            end else begin
                wait_strobe();
            end
        end
    endtask

    task automatic send_frame(input bit to_p, input logic [7:0] d, input bit par_bit,
                              input bit stop_bit, input bit ready_at_commit);
        drive(to_p, 1'b1);
        repeat (4) wait_strobe();
        bit_period(to_p, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bit_period(to_p, d[i], 1'b0);
        if (to_p) bit_period(to_p, par_bit, 1'b0);
        bit_period(to_p, stop_bit, ready_at_commit);
    endtask

    task automatic expect_frame(input string tag, input bit to_p, input logic [9:0] exp);
        logic [9:0] got;
        got = 10'h3FF;
        if (to_p) begin
            chk({tag, "_count"}, 32'(gotp_q.size()), 32'd1);
            if (gotp_q.size() > 0) got = gotp_q.pop_front();
            gotp_q.delete();
        end else begin
            chk({tag, "_count"}, 32'(got_q.size()), 32'd1);
            if (got_q.size() > 0) got = got_q.pop_front();
            got_q.delete();
        end
        chk({tag, "_frame"}, 32'(got), 32'(exp));
    endtask

    initial begin
        logic [7:0] d;
        bit         stop_b;
        bit         par_b;

        rst_n      = 1'b0;
        rxd        = 1'b1;
        rxd_p      = 1'b1;
        rx_ready   = 1'b1;
        rx_ready_p = 1'b1;
        repeat (5) @(posedge clki);
        #1;
        chk("reset_rx_data",    32'(rx_data),    32'h0);
        chk("reset_rx_valid",   32'(rx_valid),   32'h0);
        chk("reset_frame_err",  32'(frame_err),  32'h0);
        chk("reset_parity_err", 32'(parity_err), 32'h0);
        chk("reset_overrun",    32'(overrun),    32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clki);

        // Single frame 0xA5, 8N1.
        valid_cycles = 0;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
        expect_frame("single_a5", 1'b0, model(8'hA5, 1'b0, 1'b0, 1'b1));
        chk("single_valid_cycles", 32'(valid_cycles), 32'd1);

        // False start: 4 strobes low, then idle.
        drive(1'b0, 1'b0);
        repeat (4) wait_strobe();
        drive(1'b0, 1'b1);
        repeat (40) wait_strobe();
        chk("false_start_no_frame", 32'(got_q.size()), 32'd0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
        expect_frame("after_false_3c", 1'b0, model(8'h3C, 1'b0, 1'b0, 1'b1));

        // Framing error followed by a break.
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        repeat (40) wait_strobe();
        expect_frame("break_frame", 1'b0, model(8'h00, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
        expect_frame("after_break_55", 1'b0, model(8'h55, 1'b0, 1'b0, 1'b1));

        // Even parity on 0x0F.
        send_frame(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0);
        expect_frame("parity_good", 1'b1, model(8'h0F, 1'b1, 1'b0, 1'b1));
        send_frame(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
        expect_frame("parity_bad", 1'b1, model(8'h0F, 1'b1, 1'b1, 1'b1));

        // Overrun, then accept coinciding with a commit.
        rx_ready = 1'b0;
        ovr_cnt  = 0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
        chk("overrun_pulses",   32'(ovr_cnt),  32'd1);
        chk("overrun_hold_data", 32'(rx_data), 32'h11);
        chk("overrun_hold_valid", 32'(rx_valid), 32'h1);
        send_frame(1'b0, 8'h33, 1'b0, 1'b1, 1'b1);
        chk("simul_data",       32'(rx_data),  32'h33);
        chk("simul_valid",      32'(rx_valid), 32'h1);
        chk("simul_no_overrun", 32'(ovr_cnt),  32'd1);
        got_q.delete();

        // Reset during data bit 3 of 0x81.
        d = 8'h81;
        drive(1'b0, 1'b1);
        repeat (4) wait_strobe();
        drive(1'b0, 1'b0);
        repeat (16) wait_strobe();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, d[i]);
            repeat (16) wait_strobe();
        end
        drive(1'b0, d[3]);
        repeat (6) wait_strobe();
        #1;
        rxd   = 1'b1;
        rst_n = 1'b0;
        @(posedge clki);
        #1 rst_n = 1'b1;
        chk("midreset_rx_data",    32'(rx_data),    32'h0);
        chk("midreset_rx_valid",   32'(rx_valid),   32'h0);
        chk("midreset_frame_err",  32'(frame_err),  32'h0);
        chk("midreset_parity_err", 32'(parity_err), 32'h0);
        chk("midreset_overrun",    32'(overrun),    32'h0);
        rx_ready = 1'b1;
        repeat (40) wait_strobe();
        chk("midreset_no_frame", 32'(got_q.size()), 32'd0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        expect_frame("after_reset_81", 1'b0, model(8'h81, 1'b0, 1'b0, 1'b1));

        // Random frames with irregular strobe spacing on both instances.
        rand_gaps = 1'b1;
        ovr_cnt   = 0;
        ovr_cnt_p = 0;
        for (int n = 0; n < 8; n++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(3) != 0);
            par_b  = 1'($urandom_range(1));
            send_frame(1'b0, d, 1'b0, stop_b, 1'b0);
            expect_frame($sformatf("rand%0d", n), 1'b0, model(d, 1'b0, 1'b0, stop_b));
            d      = 8'($urandom);
            send_frame(1'b1, d, par_b, stop_b, 1'b0);
            expect_frame($sformatf("randp%0d", n), 1'b1, model(d, 1'b1, par_b, stop_b));
        end
        chk("rand_no_overrun",   32'(ovr_cnt),   32'd0);
        chk("rand_no_overrun_p", 32'(ovr_cnt_p), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
